// File: rtl/branch_predict_table_if.sv
// Lookup / prediction / resolution bundle for branch_predict_table.
// The master side issues lookups and resolutions. The slave side is the table.
interface branch_predict_table_if #(
  parameter int INDEX_W = 4
);
  logic               lookup_valid;
  logic [INDEX_W-1:0] lookup_idx;
  logic               lookup_ready;
  logic               pred_valid;
  logic               pred_taken;
  logic               result_strob;
  logic               result;
  logic               mispredict_valid;
  logic               mispredict;
  logic [15:0]        stat_resolved;
  logic [15:0]        stat_mispred;

  modport master (
    output lookup_valid, lookup_idx, result_strob, result,
    input  lookup_ready, pred_valid, pred_taken, mispredict_valid, mispredict,
           stat_resolved, stat_mispred
  );

  modport slave (
    input  lookup_valid, lookup_idx, result_strob, result,
    output lookup_ready, pred_valid, pred_taken, mispredict_valid, mispredict,
           stat_resolved, stat_mispred
  );
endinterface

// File: rtl/branch_predict_table.sv
// Two-bit pattern-history table with an in-order in-flight queue of predictions.
// The optional resolved/mispredict statistics counters are enabled by defining PRED_STATS_EN.
module branch_predict_table #(
  parameter int INDEX_W = 4,
  parameter int QDEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_table_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_W;
  localparam int QW    = $clog2(QDEPTH);
  localparam int CW    = QW + 1;
  localparam logic [QW-1:0] PTR_ONE  = QW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

  // Saturating-counter transition: a miss from a weak state falls straight to 0.
  function automatic logic [1:0] next_state(input logic [1:0] s, input logic taken);
    logic [1:0] ns;
    case (s)
      2'd0:    ns = taken ? 2'd1 : 2'd0;
      2'd1:    ns = taken ? 2'd3 : 2'd0;
      2'd2:    ns = taken ? 2'd3 : 2'd0;
      2'd3:    ns = taken ? 2'd3 : 2'd2;
      default: ns = 2'd0;
    endcase
    return ns;
  endfunction

  logic [1:0]         table_r  [DEPTH];
  logic [INDEX_W-1:0] q_idx_r  [QDEPTH];
  logic               q_pred_r [QDEPTH];
  logic [QW-1:0]      wr_ptr_r;
  logic [QW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               pred_valid_r;
  logic               pred_taken_r;
  logic               mispredict_valid_r;
  logic               mispredict_r;

  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic [INDEX_W-1:0] head_idx_s;
  logic               head_pred_s;

  // Handshake decode; a full queue refuses lookups even when a pop frees a slot this cycle.
  always_comb begin
    full_s      = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    head_idx_s  = q_idx_r[rd_ptr_r];
    head_pred_s = q_pred_r[rd_ptr_r];
    if (count_r == CNT_FULL) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (bus.lookup_valid && !full_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (bus.result_strob && (count_r != CNT_ZERO)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign bus.lookup_ready = !full_s;

  // Counter table and queue storage; lookups sample the pre-update table value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) table_r[i] <= 2'd0;
      for (int j = 0; j < QDEPTH; j++) begin
        q_idx_r[j]  <= '0;
        q_pred_r[j] <= 1'b0;
      end
    end else begin
      if (pop_s) begin
        table_r[head_idx_s] <= next_state(table_r[head_idx_s], bus.result);
      end
      if (push_s) begin
        q_idx_r[wr_ptr_r]  <= bus.lookup_idx;
        q_pred_r[wr_ptr_r] <= table_r[bus.lookup_idx][1];
      end
    end
  end

  // Queue pointers, occupancy and registered prediction/resolution outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r           <= '0;
      rd_ptr_r           <= '0;
      count_r            <= CNT_ZERO;
      pred_valid_r       <= 1'b0;
      pred_taken_r       <= 1'b0;
      mispredict_valid_r <= 1'b0;
      mispredict_r       <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      pred_valid_r       <= push_s;
      pred_taken_r       <= push_s ? table_r[bus.lookup_idx][1] : 1'b0;
      mispredict_valid_r <= pop_s;
      mispredict_r       <= pop_s ? (bus.result != head_pred_s) : 1'b0;
    end
  end

  assign bus.pred_valid       = pred_valid_r;
  assign bus.pred_taken       = pred_taken_r;
  assign bus.mispredict_valid = mispredict_valid_r;
  assign bus.mispredict       = mispredict_r;

`ifdef PRED_STATS_EN
  logic [15:0] stat_resolved_r;
  logic [15:0] stat_mispred_r;

  // Saturating resolution statistics, updated alongside mispredict_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved_r <= 16'h0000;
      stat_mispred_r  <= 16'h0000;
    end else if (pop_s) begin
      if (stat_resolved_r != 16'hFFFF) stat_resolved_r <= stat_resolved_r + 16'h0001;
      if ((bus.result != head_pred_s) && (stat_mispred_r != 16'hFFFF)) begin
        stat_mispred_r <= stat_mispred_r + 16'h0001;
      end
    end
  end

  assign bus.stat_resolved = stat_resolved_r;
  assign bus.stat_mispred  = stat_mispred_r;
`else
  assign bus.stat_resolved = 16'h0000;
  assign bus.stat_mispred  = 16'h0000;
`endif
endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table: queue-based reference model checked every cycle,
// plus literal expectations from hand-traced sequences.
module tb_branch_predict_table;
  logic clk;
  logic rst_n;

  branch_predict_table_if #(.INDEX_W(4)) bus ();

  branch_predict_table #(.INDEX_W(4), .QDEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { int idx; bit p; } ent_t;
  ent_t q[$];
  int   tbl[16];
  bit   exp_pv, exp_pt, exp_mv, exp_mp;
  int   exp_res, exp_mis;
  int   nxt_taken[4]     = '{1, 3, 3, 3};
  int   nxt_not_taken[4] = '{0, 0, 0, 2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counters as integers, in-flight predictions as a queue.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        for (int i = 0; i < 16; i++) tbl[i] = 0;
        exp_pv = 0; exp_pt = 0; exp_mv = 0; exp_mp = 0;
        exp_res = 0; exp_mis = 0;
      end else begin
        bit acc, pop;
        int li;
        ent_t e;
        li  = int'(bus.lookup_idx);
        acc = bus.lookup_valid && (q.size() < 4);
        pop = bus.result_strob && (q.size() > 0);
        exp_pv = acc;
        exp_pt = acc ? (tbl[li] >= 2) : 1'b0;
        e.idx = li;
        e.p   = (tbl[li] >= 2);
        exp_mv = pop;
        exp_mp = 0;
        if (pop) begin
          ent_t h;
          h = q.pop_front();
          exp_mp = (bus.result != h.p);
          tbl[h.idx] = bus.result ? nxt_taken[tbl[h.idx]] : nxt_not_taken[tbl[h.idx]];
          if (exp_res < 65535) exp_res++;
          if (exp_mp && exp_mis < 65535) exp_mis++;
        end
        if (acc) q.push_back(e);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("pred_valid", bus.pred_valid, exp_pv);
      if (exp_pv) chk("pred_taken", bus.pred_taken, exp_pt);
      chk("mispredict_valid", bus.mispredict_valid, exp_mv);
      if (exp_mv) chk("mispredict", bus.mispredict, exp_mp);
      chk("lookup_ready", bus.lookup_ready, (q.size() < 4));
`ifdef PRED_STATS_EN
      chk("stat_resolved", bus.stat_resolved, exp_res);
      chk("stat_mispred", bus.stat_mispred, exp_mis);
`else
      chk("stat_resolved", bus.stat_resolved, 0);
      chk("stat_mispred", bus.stat_mispred, 0);
`endif
    end
  end

  task automatic step(input logic lv, input logic [3:0] li, input logic rs, input logic rr);
    bus.lookup_valid = lv;
    bus.lookup_idx   = li;
    bus.result_strob = rs;
    bus.result       = rr;
    @(posedge clk);
    #1;
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = 4'd0;
    bus.result_strob = 1'b0;
    bus.result       = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = 4'd0;
    bus.result_strob = 1'b0;
    bus.result       = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_ready", bus.lookup_ready, 1);
    chk("rst_pred_valid", bus.pred_valid, 0);
    chk("rst_pred_taken", bus.pred_taken, 0);
    chk("rst_mispredict_valid", bus.mispredict_valid, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First lookup after reset
    step(1'b1, 4'd5, 1'b0, 1'b0);
    chk("idx5_pv", bus.pred_valid, 1);
    chk("idx5_pt", bus.pred_taken, 0);
    chk("idx5_ready", bus.lookup_ready, 1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("idx5_mp", bus.mispredict, 0);

    // idx 2 walks 0->1->3->2
    step(1'b1, 4'd2, 1'b0, 1'b0); chk("idx2_pt0", bus.pred_taken, 0);
    step(1'b0, 4'd0, 1'b1, 1'b1); chk("idx2_mp0", bus.mispredict, 1);
    step(1'b1, 4'd2, 1'b0, 1'b0); chk("idx2_pt1", bus.pred_taken, 0);
    step(1'b0, 4'd0, 1'b1, 1'b1); chk("idx2_mp1", bus.mispredict, 1);
    step(1'b1, 4'd2, 1'b0, 1'b0); chk("idx2_pt2", bus.pred_taken, 1);
    step(1'b0, 4'd0, 1'b1, 1'b0); chk("idx2_mp2", bus.mispredict, 1);

    // Fill the queue, then probe full behaviour
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    chk("full_ready", bus.lookup_ready, 0);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    chk("full_no_pv", bus.pred_valid, 0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("after_pop_ready", bus.lookup_ready, 1);
    step(1'b1, 4'd6, 1'b0, 1'b0);
    step(1'b1, 4'd6, 1'b1, 1'b0);
    chk("full_pop_no_pv", bus.pred_valid, 0);
    chk("full_pop_mv", bus.mispredict_valid, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0);

    // Same-cycle lookup and resolve on idx 7 (entry 1, taken)
    step(1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 4'd7, 1'b0, 1'b0);
    step(1'b1, 4'd7, 1'b1, 1'b1);
    chk("same_cycle_pt", bus.pred_taken, 0);
    chk("same_cycle_mv", bus.mispredict_valid, 1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 4'd7, 1'b0, 1'b0);
    chk("idx7_after_pt", bus.pred_taken, 1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    chk("idx7_after_mp", bus.mispredict, 0);

    // Strobe with an empty queue
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("empty_strobe_mv", bus.mispredict_valid, 0);
    step(1'b1, 4'd7, 1'b0, 1'b0);
    chk("empty_strobe_tbl", bus.pred_taken, 1);
    step(1'b0, 4'd0, 1'b1, 1'b1);

    // Back-to-back overlapping lookups and resolutions
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 2), (i > 0), i[0]);
    step(1'b0, 4'd0, 1'b1, 1'b1);

    // Asynchronous reset mid-operation discards in-flight predictions
    step(1'b1, 4'd12, 1'b0, 1'b0);
    step(1'b1, 4'd13, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pv", bus.pred_valid, 0);
    chk("midrst_ready", bus.lookup_ready, 1);
    chk("midrst_stat", bus.stat_resolved, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'd0, 1'b1, 1'b1);
    chk("post_rst_strobe_mv", bus.mispredict_valid, 0);

    // Three resolutions, two mispredicted
    step(1'b1, 4'd10, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b1, 4'd10, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd11, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
`ifdef PRED_STATS_EN
    chk("stat_resolved_lit", bus.stat_resolved, 3);
    chk("stat_mispred_lit", bus.stat_mispred, 2);
`else
    chk("stat_resolved_lit", bus.stat_resolved, 0);
    chk("stat_mispred_lit", bus.stat_mispred, 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
